// File: rtl/fifo_axis_out.sv
// fifo_axis_out
//   Drain stage that sits after a synchronous FIFO. It pops the FIFO,
//   captures each word in a 2-entry in-order buffer and presents the words
//   as an AXI4-Stream master. With tready held high the stream carries one
//   beat per clock. Backpressure does not lose any data.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous reset, active low
//   fifo_empty     registered empty flag from the FIFO
//   fifo_pop       pop strobe to the FIFO (combinational)
//   fifo_pop_data  FIFO read data, valid the cycle after an accepted pop
//   m_axis_tvalid  stream valid (registered)
//   m_axis_tready  stream ready from the consumer
//   m_axis_tdata   stream data, taken from the head buffer entry
//   m_axis_tlast   packet boundary marker (tied to 0 unless the feature is on)
//   level          output buffer occupancy, 0..2
//
// Optional feature: define FIFO_AXIS_OUT_LAST_EN to generate m_axis_tlast
// on every PKT_BEATS-th accepted beat.

module fifo_axis_out #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [1:0]            level
);

  logic [1:0]            occ;
  logic                  inflight;
  logic                  drain;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  // A packet length below one beat is not a legal configuration, so nothing
  // is built for it.
  if (PKT_BEATS < 1) begin : g_pkt_beats_invalid
  end

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = buf0;
  assign level         = occ;

  // The next occupancy also bounds the committed storage. A pop is issued
  // only when the word it returns is sure to have a free slot. Because
  // tready feeds this path, a slot freed by this cycle's drain can be
  // refilled at once.
  always_comb begin
    drain    = m_axis_tvalid & m_axis_tready;
    occ_next = occ + {1'b0, inflight} - {1'b0, drain};
    fifo_pop = ~fifo_empty & (occ_next <= 2'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      occ      <= occ_next;
      inflight <= fifo_pop & ~fifo_empty;
    end
  end

  // The buffer contents need no reset because tvalid qualifies them.
  // A word arriving while the queue drains from 2 goes to entry1, since the
  // old entry1 moves into the head position in the same cycle.
  always_ff @(posedge clk) begin
    if (drain && occ == 2'd2) begin
      buf0 <= buf1;
      if (inflight) buf1 <= fifo_pop_data;
    end else if (inflight) begin
      if (occ == 2'd0 || drain) buf0 <= fifo_pop_data;
      else                      buf1 <= fifo_pop_data;
    end
  end

`ifdef FIFO_AXIS_OUT_LAST_EN
  localparam int CW = $clog2(PKT_BEATS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_BEATS - 1);

  logic [CW-1:0] beat_cnt;

  assign m_axis_tlast = m_axis_tvalid & (beat_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (drain) begin
      if (m_axis_tlast) beat_cnt <= '0;
      else              beat_cnt <= beat_cnt + 1'b1;
    end
  end
`else
  assign m_axis_tlast = 1'b0;
`endif

endmodule
